uart_mmio_ctrl: RTL and testbench

- Memory-mapped UART controller placed between the single-cycle core's UART strobes and the UART serializer/deserializer.
- TX side: buffers bytes from `sb` to 0x400 in a TX FIFO and schedules them onto the uart_tx core with a start/busy handshake.
- RX side: buffers bytes received by uart_rx in an RX FIFO and serves them to `lb` from 0x404 in the same cycle as the load.

---
 rtl/uart_mmio_ctrl.sv | 125 ++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// MMIO UART glue: TX/RX byte FIFOs between the core's sb/lb strobes
// and the uart_tx/uart_rx cores, with a start/busy launch FSM on TX.
module uart_mmio_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        UART_WRITE_EN,
    input  logic        UART_READ_EN,
    input  logic [7:0]  WDATA,
    output logic [31:0] RDATA,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        tx_full,
    output logic        rx_empty,
    output logic        rx_overrun
);

    localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, START, SEND} state_e;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    state_e        state_q, state_d;
    logic [1:0]    to_q, to_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          ovr_q;
    logic          tx_pop, tx_push, rx_pop, rx_push, rx_full;

    assign tx_full    = (tx_cnt_q == FULL_C);
    assign rx_full    = (rx_cnt_q == FULL_C);
    assign rx_empty   = (rx_cnt_q == '0);
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign rx_overrun = ovr_q;

    // A full FIFO still accepts when the same edge frees a slot.
    assign tx_push = UART_WRITE_EN && (!tx_full || tx_pop);
    assign rx_pop  = UART_READ_EN && !rx_empty;
    assign rx_push = rx_valid && (!rx_full || rx_pop);

    assign RDATA = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rptr_q]};

    always_comb begin
        state_d    = state_q;
        to_d       = to_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        tx_pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_cnt_q != '0 && !tx_busy) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_mem[tx_rptr_q];
                    tx_start_d = 1'b1;
                    to_d       = '0;
                    state_d    = START;
                end
            end
            START: begin
                // Give up on busy after three quiet cycles.
                if (tx_busy)            state_d = SEND;
                else if (to_q == 2'd2)  state_d = IDLE;
                else                    to_d = to_q + 2'd1;
            end
            SEND: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
        else if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - CNT_ONE;
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
        else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= WDATA;
        if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            state_q    <= IDLE;
            to_q       <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
            if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
            if (rx_valid && !rx_push) ovr_q <= 1'b1;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            state_q    <= state_d;
            to_q       <= to_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: directed scenarios plus randomized
// traffic checked against queue-based FIFO models.
module tb_uart_mmio_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0, re = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        rxv = 1'b0;
    logic        tx_full, rx_empty, rx_overrun;

    always #5 clk = ~clk;

    uart_mmio_ctrl #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset(reset),
        .UART_WRITE_EN(we), .UART_READ_EN(re),
        .WDATA(wdata), .RDATA(rdata),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rxd), .rx_valid(rxv),
        .tx_full(tx_full), .rx_empty(rx_empty), .rx_overrun(rx_overrun)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] obs_q[$];
    int         start_cyc[$];
    logic       prev_start = 1'b0;
    int         dbl_starts = 0;
    bit         auto_busy = 1'b0;
    int         busy_len = 3;
    int         busy_left = 0;

    // Advance one edge; record launched bytes and model uart_tx busy.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_start === 1'b1) begin
            obs_q.push_back(tx_data);
            start_cyc.push_back(cyc);
            if (prev_start) dbl_starts++;
            if (auto_busy) busy_left = busy_len;
        end
        prev_start = (tx_start === 1'b1);
        if (auto_busy) begin
            tx_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
    endtask

    task automatic store(input logic [7:0] b);
        we = 1'b1; wdata = b; tick(); we = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rxv = 1'b1; rxd = b; tick(); rxv = 1'b0;
    endtask

    task automatic rd(output logic [31:0] r);
        r = rdata; re = 1'b1; tick(); re = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; tick(); tick(); reset = 1'b1;
    endtask

    task automatic drain(input int n);
        int t;
        t = 0;
        while (obs_q.size() < n && t < 400) begin tick(); t++; end
        vectors++;
        if (obs_q.size() < n) begin
            miscompares++;
            $display("FAIL drain_timeout got %0d bytes want %0d", obs_q.size(), n);
        end
        repeat (20) tick();
    endtask

    task automatic test_reset();
        we = 1'b1; wdata = 8'h55; rxv = 1'b1; rxd = 8'h66;
        reset = 1'b0; tick(); tick();
        vectors++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || tx_full !== 1'b0 ||
            rx_empty !== 1'b1 || rx_overrun !== 1'b0 || rdata !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL rst_state got st=%b td=%h tf=%b re=%b ov=%b rd=%h want 0 00 0 1 0 ffffffff",
                     tx_start, tx_data, tx_full, rx_empty, rx_overrun, rdata);
        end
        we = 1'b0; rxv = 1'b0; reset = 1'b1;
        obs_q.delete();
        repeat (4) tick();
        vectors++;
        if (obs_q.size() != 0 || rx_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_quiet got starts=%0d rx_empty=%b want 0 1", obs_q.size(), rx_empty);
        end
    endtask

    task automatic test_single_store();
        int n;
        auto_busy = 1'b0; tx_busy = 1'b0;
        store(8'h41);
        vectors++;
        if (tx_start !== 1'b0) begin
            miscompares++; $display("FAIL lat_early got %b want 0", tx_start);
        end
        tick();
        vectors++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
            miscompares++;
            $display("FAIL lat_start got st=%b td=%h want 1 41", tx_start, tx_data);
        end
        tx_busy = 1'b1;
        n = 0;
        repeat (10) begin tick(); if (tx_start === 1'b1) n++; end
        vectors++;
        if (n != 0) begin
            miscompares++; $display("FAIL busy_quiet got %0d starts want 0", n);
        end
        tx_busy = 1'b0; tick();
        store(8'h42); tick();
        vectors++;
        if (tx_start !== 1'b1 || tx_data !== 8'h42) begin
            miscompares++;
            $display("FAIL idle_return got st=%b td=%h want 1 42", tx_start, tx_data);
        end
        tick();
        vectors++;
        if (tx_start !== 1'b0) begin
            miscompares++; $display("FAIL one_pulse got %b want 0", tx_start);
        end
        repeat (6) tick();
    endtask

    task automatic test_tx_fill();
        obs_q.delete(); dbl_starts = 0;
        auto_busy = 1'b1; busy_len = 1000;
        for (int i = 0; i < 9; i++) store(8'(i));
        vectors++;
        if (tx_full !== 1'b1 || obs_q.size() != 1 || obs_q[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL fill got full=%b launched=%0d want 1 1", tx_full, obs_q.size());
        end
        store(8'hAA);
        vectors++;
        if (tx_full !== 1'b1) begin
            miscompares++; $display("FAIL fill_hold got %b want 1", tx_full);
        end
        busy_len = 2; busy_left = 0;
        drain(9);
        vectors++;
        if (obs_q.size() != 9) begin
            miscompares++; $display("FAIL fill_count got %0d want 9", obs_q.size());
        end
        for (int i = 1; i < 9 && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== 8'(i)) begin
                miscompares++;
                $display("FAIL fill_order[%0d] got %h want %h", i, obs_q[i], 8'(i));
            end
        end
        vectors++;
        if (tx_full !== 1'b0 || dbl_starts != 0) begin
            miscompares++;
            $display("FAIL fill_end got full=%b dbl=%0d want 0 0", tx_full, dbl_starts);
        end
        auto_busy = 1'b0; tx_busy = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_start_timeout();
        auto_busy = 1'b0; tx_busy = 1'b0;
        obs_q.delete(); start_cyc.delete();
        store(8'hC3); store(8'h3C);
        repeat (20) tick();
        vectors++;
        if (obs_q.size() != 2) begin
            miscompares++; $display("FAIL to_count got %0d want 2", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0] !== 8'hC3 || obs_q[1] !== 8'h3C) begin
                miscompares++;
                $display("FAIL to_bytes got %h %h want c3 3c", obs_q[0], obs_q[1]);
            end
            vectors++;
            if (start_cyc[1] - start_cyc[0] != 4) begin
                miscompares++;
                $display("FAIL to_gap got %0d want 4", start_cyc[1] - start_cyc[0]);
            end
        end
    endtask

    task automatic test_random_tx();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int k;
        for (int r = 0; r < 4; r++) begin
            obs_q.delete(); exp_q.delete(); dbl_starts = 0;
            auto_busy = 1'b1; busy_len = int'($urandom_range(1, 4));
            k = int'($urandom_range(1, 6));
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom);
                store(b); exp_q.push_back(b);
                repeat ($urandom_range(0, 2)) tick();
            end
            drain(k);
            vectors++;
            if (obs_q.size() != k || dbl_starts != 0) begin
                miscompares++;
                $display("FAIL rtx_count got %0d dbl=%0d want %0d 0", obs_q.size(), dbl_starts, k);
            end
            for (int i = 0; i < k && i < obs_q.size(); i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rtx_byte[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        auto_busy = 1'b0; tx_busy = 1'b0;
    endtask

    task automatic test_rx_wrap();
        logic [7:0]  b;
        logic [31:0] r;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            rx_push(b);
            rd(r);
            vectors++;
            if (r !== {24'h0, b}) begin
                miscompares++; $display("FAIL wrap[%0d] got %h want %h", i, r, {24'h0, b});
            end
        end
        vectors++;
        if (rx_empty !== 1'b1 || rx_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_end got empty=%b ovr=%b want 1 0", rx_empty, rx_overrun);
        end
    endtask

    task automatic test_rx_overrun();
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [31:0] r;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            rx_push(b);
            if (i < 8) q.push_back(b);
            if (i == 7) begin
                vectors++;
                if (rx_overrun !== 1'b0) begin
                    miscompares++; $display("FAIL ovr_early got %b want 0", rx_overrun);
                end
            end
        end
        vectors++;
        if (rx_overrun !== 1'b1) begin
            miscompares++; $display("FAIL ovr_set got %b want 1", rx_overrun);
        end
        for (int i = 0; i < 8; i++) begin
            rd(r);
            vectors++;
            if (r !== {24'h0, q[i]} || rx_overrun !== 1'b1) begin
                miscompares++;
                $display("FAIL ovr_read[%0d] got %h ovr=%b want %h 1", i, r, rx_overrun, {24'h0, q[i]});
            end
        end
        rd(r);
        vectors++;
        if (r !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL ovr_empty got %h want ffffffff", r);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [31:0] r;
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom); rx_push(b); q.push_back(b);
        end
        r = rdata; re = 1'b1; rxv = 1'b1; rxd = 8'h5A;
        tick();
        re = 1'b0; rxv = 1'b0;
        vectors++;
        if (r !== {24'h0, q[0]} || rx_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL simul got %h ovr=%b want %h 0", r, rx_overrun, {24'h0, q[0]});
        end
        void'(q.pop_front()); q.push_back(8'h5A);
        for (int i = 0; i < 8; i++) begin
            rd(r);
            vectors++;
            if (r !== {24'h0, q[i]}) begin
                miscompares++;
                $display("FAIL simul_read[%0d] got %h want %h", i, r, {24'h0, q[i]});
            end
        end
        vectors++;
        if (rx_empty !== 1'b1) begin
            miscompares++; $display("FAIL simul_count got empty=%b want 1", rx_empty);
        end
        obs_q.delete();
        auto_busy = 1'b1; busy_len = 1000;
        store(8'h77); store(8'h78); tick(); tick(); tick();
        rx_push(8'h11);
        reset = 1'b0; tick(); reset = 1'b1;
        vectors++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || tx_full !== 1'b0 ||
            rx_empty !== 1'b1 || rdata !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL send_rst got st=%b td=%h tf=%b re=%b rd=%h want 0 00 0 1 ffffffff",
                     tx_start, tx_data, tx_full, rx_empty, rdata);
        end
        n = obs_q.size();
        repeat (5) tick();
        busy_left = 0;
        repeat (10) tick();
        vectors++;
        if (obs_q.size() != n) begin
            miscompares++;
            $display("FAIL send_rst_quiet got %0d starts want %0d", obs_q.size(), n);
        end
        auto_busy = 1'b0; tx_busy = 1'b0;
    endtask

    task automatic test_random_rx();
        logic [7:0] q[$];
        logic       ovr;
        logic       v, rdn, pop, push;
        logic [7:0] b;
        logic [31:0] expd;
        do_reset();
        ovr = 1'b0;
        for (int c = 0; c < 300; c++) begin
            expd = (q.size() == 0) ? 32'hFFFF_FFFF : {24'h0, q[0]};
            vectors++;
            if (rdata !== expd || rx_empty !== (q.size() == 0) || rx_overrun !== ovr) begin
                miscompares++;
                $display("FAIL rrx[%0d] got %h e=%b o=%b want %h %b %b",
                         c, rdata, rx_empty, rx_overrun, expd, (q.size() == 0), ovr);
            end
            v   = (c < 150) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) != 0);
            rdn = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) != 0);
            b   = 8'($urandom);
            pop  = rdn && (q.size() > 0);
            push = v && (q.size() < DEPTH || pop);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(b);
            if (v && !push) ovr = 1'b1;
            rxv = v; rxd = b; re = rdn;
            tick();
            rxv = 1'b0; re = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_tx_fill();
        test_start_timeout();
        test_random_tx();
        test_rx_wrap();
        test_rx_overrun();
        test_simultaneous();
        test_random_rx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
